// File: rtl/base_sram_fifo.sv
// base_sram_fifo: valid/ready FIFO backed by an external 1R1W SRAM with
// one-cycle read latency. The block owns the SRAM pointers and occupancy and
// keeps a two-entry output buffer so reads can be issued ahead of the
// consumer and full throughput is sustained.
//
// Optional feature: define BASE_SRAM_FIFO_BYPASS_EN to let an input skip the
// SRAM and land directly in the output buffer when nothing is stored or in
// flight, cutting empty latency from three cycles to one.
module base_sram_fifo #(
   parameter int unsigned width = 8,
   parameter int unsigned aw    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_v,
   input  logic [width-1:0] i_d,
   output logic             i_r,
   output logic             o_v,
   output logic [width-1:0] o_d,
   input  logic             o_r,
   output logic             wr_en,
   output logic [aw-1:0]    wr_addr,
   output logic [width-1:0] wr_d,
   output logic             rd_en,
   output logic [aw-1:0]    rd_addr,
   input  logic [width-1:0] rd_d,
   output logic [aw:0]      o_cnt
);

   // Count value meaning every SRAM entry is occupied.
   localparam logic [aw:0] FullCnt = {1'b1, {aw{1'b0}}};

   logic [aw:0]      cnt_q, cnt_d;
   logic [aw-1:0]    wptr_q, wptr_d;
   logic [aw-1:0]    rptr_q, rptr_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       buf_cnt_q, buf_cnt_d;
   logic [width-1:0] buf0_q, buf0_d;
   logic [width-1:0] buf1_q, buf1_d;

   logic             accept;
   logic             pop;
   logic             bypass;
   logic             push;
   logic [width-1:0] push_data;
   logic [1:0]       buf_after_pop;
   logic [1:0]       occ_after;

   // Handshakes and SRAM strobes. i_r looks only at the registered count so
   // o_r never reaches it combinationally.
   always_comb begin
      i_r           = reset & (cnt_q != FullCnt);
      accept        = i_v & i_r;
      o_v           = (buf_cnt_q != 2'd0);
      pop           = o_v & o_r;
      buf_after_pop = buf_cnt_q - {1'b0, pop};
      // Buffer slots already spoken for, counting the read returning now.
      occ_after     = buf_after_pop + {1'b0, inflight_q};
      rd_en         = (cnt_q != '0) & (occ_after < 2'd2);
`ifdef BASE_SRAM_FIFO_BYPASS_EN
      // Safe for ordering: nothing older sits in SRAM or in the read pipe.
      bypass        = accept & (cnt_q == '0) & ~inflight_q & (buf_after_pop < 2'd2);
`else
      bypass        = 1'b0;
`endif
      wr_en         = accept & ~bypass;
      wr_addr       = wptr_q;
      wr_d          = i_d;
      rd_addr       = rptr_q;
      o_d           = buf0_q;
      o_cnt         = cnt_q;
   end

   // Next-state for pointers, SRAM occupancy and the read-in-flight flag.
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      inflight_d = rd_en;
      if (wr_en) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (rd_en) begin
         rptr_d = rptr_q + 1'b1;
      end
      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Output buffer: pop shifts the head out, then returning read data (or a
   // bypassed input) is appended behind whatever remains.
   always_comb begin
      push      = inflight_q | bypass;
      push_data = inflight_q ? rd_d : i_d;
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      buf_cnt_d = buf_after_pop;
      if (pop) begin
         buf0_d = buf1_q;
      end
      if (push) begin
         if (buf_after_pop == 2'd0) begin
            buf0_d = push_data;
         end else begin
            buf1_d = push_data;
         end
         buf_cnt_d = buf_after_pop + 2'd1;
      end
   end

   // State registers; reset discards any read still in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         inflight_q <= 1'b0;
         buf_cnt_q  <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         inflight_q <= inflight_d;
         buf_cnt_q  <= buf_cnt_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

endmodule

// File: doc/base_sram_fifo.md
# base_sram_fifo

Valid/ready FIFO whose storage lives in an external one-read/one-write SRAM with one-cycle read latency; the block owns pointers, occupancy, SRAM write/read strobes, and a two-entry output buffer that absorbs read latency. It sits directly upstream of the stream latch stages in the base library and feeds them a clean valid/ready stream at full throughput.

## Interface
- `width`, 8, data bits per entry
- `aw`, 4, SRAM address bits; depth = 2^aw entries (aw >= 1)

- `clk`  in  1  clock; all logic rising-edge
- `reset`  in  1  asynchronous, active-low; asserted when 0
- `i_v`  in  1  input valid
- `i_d`  in  width  input data
- `i_r`  out  1  input ready
- `o_v`  out  1  output valid
- `o_d`  out  width  output data
- `o_r`  in  1  output ready
- `wr_en`  out  1  SRAM write strobe
- `wr_addr`  out  aw  SRAM write address
- `wr_d`  out  width  SRAM write data
- `rd_en`  out  1  SRAM read strobe
- `rd_addr`  out  aw  SRAM read address
- `rd_d`  in  width  SRAM read data, valid the cycle after `rd_en`
- `o_cnt`  out  aw+1  entries held in SRAM (written, not yet read)

## Operation
- Input accept: `i_v & i_r`. `i_r = reset & (o_cnt != 2^aw)`; combinational from registered count only.
- On accept: `wr_en=1`, `wr_addr=wptr`, `wr_d=i_d` in the same cycle; wptr increments (aw bits, wraps 2^aw-1 -> 0).
- Read issue: `rd_en = (o_cnt != 0) & (buf_cnt + inflight + (o_v & o_r ? -1 : 0) < 2)`, where buf_cnt (0..2) is output-buffer occupancy and inflight (0/1) is a read issued last cycle. `rd_addr=rptr`; rptr increments on issue, wraps.
- `o_cnt` next = o_cnt + accept - rd_en; simultaneous accept and read leaves it unchanged.
- No read/write hazard: a read targets only entries counted in the registered `o_cnt`, hence written at least one cycle earlier.
- Return: cycle after `rd_en`, `rd_d` is captured into the output buffer (FIFO order, 2 entries). `o_v = buf_cnt != 0`; `o_d` = head entry, registered.
- Pop: `o_v & o_r` removes head; capture and pop in the same cycle are legal at any buf_cnt.
- Full: `o_cnt==2^aw` -> `i_r=0`; a read in that cycle does not raise `i_r` until the next cycle.
- Empty: `o_cnt==0` -> `rd_en=0`; `o_v` drops once buffer drains.
- Reset (async, any time, including mid-stream): pointers, `o_cnt`, buf_cnt, inflight -> 0; in-flight read data discarded. Outputs during/after reset: `o_v=0`, `wr_en=0`, `rd_en=0`, `o_cnt=0`, `i_r=0` while asserted, 1 after release. `o_d` value don't-care.

## Timing
- Empty-FIFO latency (no bypass): accept cycle 0 -> `rd_en` cycle 1 -> capture end of cycle 2 -> `o_v=1` cycle 3.
- Steady state: one accept and one pop per cycle sustained with `o_r` held 1.
- `o_r` deassert: at most 2 entries buffered; further reads stall, SRAM absorbs input until full.
- No combinational path from `o_r` to `i_r`; `o_r` -> `rd_en` is combinational.

## Configuration
- `BASE_SRAM_FIFO_BYPASS_EN` defined: when `o_cnt==0`, inflight==0 and buffer has room (after same-cycle pop), an accepted input is written directly into the output buffer, not SRAM (`wr_en=0`); `o_v=1` cycle 1. Ordering preserved because bypass only occurs with nothing in SRAM or in flight.
- Not defined: every entry goes through SRAM; empty latency 3 cycles.

## Test plan
- Reset release, `i_v=1`, `i_d=0x5A`, `o_r=1`: `wr_en` cycle 0 addr 0, `rd_en` cycle 1 addr 0, `o_v=1 o_d=0x5A` cycle 3 (cycle 1 with bypass, `wr_en=0`).
- `o_r=0`, push 18 entries 0..17 with aw=4: 16 land in SRAM plus... `o_cnt` reaches 16 after buffer holds 2; `i_r=0` with exactly 18 accepted; raise `o_r`: outputs 0..17 in order.
- Streaming 100 entries with `i_v=o_r=1`: after initial latency, one output per cycle, no bubbles, `o_cnt` constant.
- Pointer wrap: 40 entries through aw=2 with random `o_r`: in-order data, addresses cycle 0..3.
- Random `i_v`/`o_r` 10k cycles vs reference queue: no loss, duplication or reorder; `o_cnt` matches model.
- Reset asserted mid-stream with a read in flight: all outputs to reset values immediately; after release first new input emerges, no stale data.
